ntt_stage_sequencer: RTL and testbench

Drives one complete in-place NTT or INTT over a polynomial stored in a dual-port coefficient RAM. It generates butterfly address pairs and twiddle indices stage by stage, fetches operands and a twiddle, and presents them to the pair of PE cells: one with `sub` tied to 0 (result `pe_p0`), one with `sub` tied to 1 (result `pe_p1`). It then writes both PE results back to the addresses they came from. It sits directly upstream of the PE pair and owns the RAM/ROM access.

---
 rtl/ntt_pkg.sv | 24 ++
 rtl/ntt_addr_gen.sv | 44 ++++
 rtl/ntt_stage_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_ntt_stage_sequencer.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// ntt_pkg
// Shared definitions for the NTT stage sequencer and its address generator.
//   ntt_state_t  : sequencer FSM states (IDLE, ISSUE, DRAIN, DONE)
//   DRAIN_CYCLES : idle cycles between stages so the last writes of a stage
//                  land before the next stage starts reading
//   PIPE_DEPTH   : cycles from a butterfly issue to its write-back
//   ctr_width()  : bit width needed to count 0..n-1 (at least 1)
package ntt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } ntt_state_t;

  localparam int DRAIN_CYCLES = 2;
  localparam int PIPE_DEPTH   = 2;

  function automatic int ctr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ntt_addr_gen.sv
// ntt_addr_gen
// Combinational butterfly address and twiddle index generator for one
// in-place radix-2 NTT stage.
//   s      in  : stage number, h = 2^s is the butterfly span
//   i      in  : butterfly index within the stage, 0 .. 2^(LOGN-1)-1
//   lower  out : address of the lower operand
//   upper  out : address of the upper operand (lower + h)
//   tw_idx out : twiddle index (i mod h) scaled by 2^(LOGN-1-s)
module ntt_addr_gen
  import ntt_pkg::*;
#(
  parameter int LOGN = 8,
  localparam int SW  = ctr_width(LOGN),
  localparam int SW1 = SW + 1
) (
  input  logic [SW-1:0]   s,
  input  logic [LOGN-2:0] i,
  output logic [LOGN-1:0] lower,
  output logic [LOGN-1:0] upper,
  output logic [LOGN-2:0] tw_idx
);

  logic [LOGN-1:0] ext;
  logic [LOGN-1:0] span;
  logic [LOGN-1:0] mask;
  logic [SW:0]     s_up;
  logic [SW:0]     tw_sh;

  // The upper index bits (i >> s) select the group of 2h words and are moved
  // up one position to make room for the lower/upper select bit; the low s
  // bits of i stay as the offset inside the group. The shift amounts are one
  // bit wider than s so that s+1 cannot wrap on the last stage.
  always_comb begin
    ext    = {1'b0, i};
    span   = LOGN'(1) << s;
    mask   = span - LOGN'(1);
    s_up   = {1'b0, s} + SW1'(1);
    tw_sh  = SW1'(LOGN - 1) - {1'b0, s};
    lower  = ((ext >> s) << s_up) | (ext & mask);
    upper  = lower + span;
    tw_idx = (i & mask[LOGN-2:0]) << tw_sh;
  end

endmodule

// File: rtl/ntt_stage_sequencer.sv
// ntt_stage_sequencer
// Runs one complete in-place NTT/INTT over a dual-port coefficient RAM,
// issuing one butterfly per cycle, feeding a pair of PE cells and writing
// both PE results back to the addresses the operands came from.
//   clk, rst_n            : clock, asynchronous active-low reset
//   start, inv            : begin a transform (IDLE only); inv latched at start
//   busy, done            : busy through the last write; done is a 1-cycle pulse
//   ra_addr, rb_addr, re  : RAM read port, data back one cycle later
//   ra_data, rb_data      : RAM read data
//   tf_addr, tf_data      : twiddle ROM {inv, index} and its data (1-cycle)
//   pe_a, pe_b, pe_tf     : registered PE operands
//   pe_inv                : latched transform direction for both PEs
//   pe_p0, pe_p1          : combinational PE results (sub=0 / sub=1)
//   wa_addr, wb_addr      : write-back addresses
//   wa_data, wb_data, we  : write-back data (pe_p0 / pe_p1) and enable
module ntt_stage_sequencer
  import ntt_pkg::*;
#(
  parameter int N    = 17,
  parameter int LOGN = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            inv,
  output logic            busy,
  output logic            done,
  output logic [LOGN-1:0] ra_addr,
  output logic [LOGN-1:0] rb_addr,
  output logic            re,
  input  logic [N-1:0]    ra_data,
  input  logic [N-1:0]    rb_data,
  output logic [LOGN-1:0] tf_addr,
  input  logic [N-1:0]    tf_data,
  output logic [N-1:0]    pe_a,
  output logic [N-1:0]    pe_b,
  output logic [N-1:0]    pe_tf,
  output logic            pe_inv,
  input  logic [N-1:0]    pe_p0,
  input  logic [N-1:0]    pe_p1,
  output logic [LOGN-1:0] wa_addr,
  output logic [LOGN-1:0] wb_addr,
  output logic [N-1:0]    wa_data,
  output logic [N-1:0]    wb_data,
  output logic            we
);

  localparam int SW = ctr_width(LOGN);
  localparam int DW = ctr_width(DRAIN_CYCLES);

  localparam logic [LOGN-2:0] LAST_BFLY  = '1;
  localparam logic [LOGN-2:0] BFLY_ONE   = (LOGN-1)'(1);
  localparam logic [SW-1:0]   LAST_STAGE = SW'(LOGN - 1);
  localparam logic [SW-1:0]   STAGE_ONE  = SW'(1);
  localparam logic [DW-1:0]   LAST_DRAIN = DW'(DRAIN_CYCLES - 1);
  localparam logic [DW-1:0]   DRAIN_ONE  = DW'(1);

  ntt_state_t      state;
  logic [SW-1:0]   stage;
  logic [LOGN-2:0] bfly;
  logic [DW-1:0]   dcnt;
  logic            inv_l;

  logic [LOGN-1:0] lower;
  logic [LOGN-1:0] upper;
  logic [LOGN-2:0] tw_idx;

  logic [PIPE_DEPTH-1:0] vld;
  logic [LOGN-1:0]       lo_dly [PIPE_DEPTH];
  logic [LOGN-1:0]       hi_dly [PIPE_DEPTH];

  ntt_addr_gen #(
    .LOGN (LOGN)
  ) u_addr_gen (
    .s      (stage),
    .i      (bfly),
    .lower  (lower),
    .upper  (upper),
    .tw_idx (tw_idx)
  );

  // Stage/butterfly sequencing. stage and bfly always name the butterfly
  // being issued in the current cycle, so the address generator output can
  // drive the RAM directly. re, busy and done are updated here on the same
  // edges as the state so they never glitch. The drain gap keeps the last
  // writes of a stage ahead of the first reads of the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      stage <= '0;
      bfly  <= '0;
      dcnt  <= '0;
      inv_l <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      re    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= ISSUE;
            inv_l <= inv;
            stage <= '0;
            bfly  <= '0;
            busy  <= 1'b1;
            re    <= 1'b1;
          end
        end
        ISSUE: begin
          if (bfly == LAST_BFLY) begin
            state <= DRAIN;
            dcnt  <= '0;
            re    <= 1'b0;
          end else begin
            bfly <= bfly + BFLY_ONE;
          end
        end
        DRAIN: begin
          if (dcnt == LAST_DRAIN) begin
            if (stage == LAST_STAGE) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= ISSUE;
              stage <= stage + STAGE_ONE;
              bfly  <= '0;
              re    <= 1'b1;
            end
          end else begin
            dcnt <= dcnt + DRAIN_ONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Issue-to-write pipeline. The valid bits and address delay lines track
  // each butterfly for PIPE_DEPTH cycles; operands are captured the cycle
  // after the issue, when RAM and ROM data arrive. The write enable is the
  // last valid bit, so an asynchronous reset removes it immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld   <= '0;
      pe_a  <= '0;
      pe_b  <= '0;
      pe_tf <= '0;
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        lo_dly[k] <= '0;
        hi_dly[k] <= '0;
      end
    end else begin
      vld       <= {vld[PIPE_DEPTH-2:0], re};
      lo_dly[0] <= lower;
      hi_dly[0] <= upper;
      for (int k = 1; k < PIPE_DEPTH; k++) begin
        lo_dly[k] <= lo_dly[k-1];
        hi_dly[k] <= hi_dly[k-1];
      end
      if (vld[0]) begin
        pe_a  <= ra_data;
        pe_b  <= rb_data;
        pe_tf <= tf_data;
      end
    end
  end

  // Read-side addresses are only presented while issuing so the ports idle
  // at zero; write data is likewise held at zero unless a write is active.
  assign ra_addr = re ? lower : '0;
  assign rb_addr = re ? upper : '0;
  assign tf_addr = re ? {inv_l, tw_idx} : '0;
  assign pe_inv  = inv_l;
  assign we      = vld[PIPE_DEPTH-1];
  assign wa_addr = lo_dly[PIPE_DEPTH-1];
  assign wb_addr = hi_dly[PIPE_DEPTH-1];
  assign wa_data = we ? pe_p0 : '0;
  assign wb_data = we ? pe_p1 : '0;

endmodule

// File: tb/tb_ntt_stage_sequencer.sv
// tb_ntt_stage_sequencer
// Self-checking bench for ntt_stage_sequencer with LOGN=3, N=17 (H=4).
// A RAM/ROM model and an additive PE pair (p0=a+b, p1=b-a) surround the DUT;
// a golden transform pushes every expected issue and write into queues when
// a transform is started, and a negedge monitor pops and compares them.
module tb_ntt_stage_sequencer;

  localparam int N          = 17;
  localparam int LOGN       = 3;
  localparam int H          = 4;
  localparam int NW         = 8;
  localparam int RUN_CYCLES = LOGN * (H + 2);

  typedef struct {
    logic [LOGN-1:0] lo;
    logic [LOGN-1:0] hi;
    logic [LOGN-1:0] tf;
  } issue_t;

  typedef struct {
    logic [LOGN-1:0] lo;
    logic [LOGN-1:0] hi;
    logic [N-1:0]    d0;
    logic [N-1:0]    d1;
    logic [N-1:0]    ptf;
  } write_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic            inv;
  logic            busy;
  logic            done;
  logic [LOGN-1:0] ra_addr;
  logic [LOGN-1:0] rb_addr;
  logic            re;
  logic [N-1:0]    ra_data = '0;
  logic [N-1:0]    rb_data = '0;
  logic [LOGN-1:0] tf_addr;
  logic [N-1:0]    tf_data = '0;
  logic [N-1:0]    pe_a;
  logic [N-1:0]    pe_b;
  logic [N-1:0]    pe_tf;
  logic            pe_inv;
  logic [N-1:0]    pe_p0;
  logic [N-1:0]    pe_p1;
  logic [LOGN-1:0] wa_addr;
  logic [LOGN-1:0] wb_addr;
  logic [N-1:0]    wa_data;
  logic [N-1:0]    wb_data;
  logic            we;

  logic [N-1:0] mem    [NW];
  logic [N-1:0] golden [NW];
  logic         preloadReq = 1'b0;

  issue_t issueQ[$];
  write_t writeQ[$];
  issue_t monIssue;
  write_t monWrite;

  int cyc = 0;
  int checkCount = 0;
  int failCount = 0;
  bit monitorOn = 1'b0;

  int              runStart;
  logic            runInv;
  int              doneCycle;
  int              doneCount;
  int              busyFirst;
  int              busyLast;
  int              busyCount;
  int              firstWriteCycle;
  logic [LOGN-1:0] firstWa;
  logic [LOGN-1:0] firstWb;
  logic [N-1:0]    firstWaData;
  logic [N-1:0]    firstWbData;

  always #5 clk = ~clk;

  ntt_stage_sequencer #(
    .N    (N),
    .LOGN (LOGN)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .inv     (inv),
    .busy    (busy),
    .done    (done),
    .ra_addr (ra_addr),
    .rb_addr (rb_addr),
    .re      (re),
    .ra_data (ra_data),
    .rb_data (rb_data),
    .tf_addr (tf_addr),
    .tf_data (tf_data),
    .pe_a    (pe_a),
    .pe_b    (pe_b),
    .pe_tf   (pe_tf),
    .pe_inv  (pe_inv),
    .pe_p0   (pe_p0),
    .pe_p1   (pe_p1),
    .wa_addr (wa_addr),
    .wb_addr (wb_addr),
    .wa_data (wa_data),
    .wb_data (wb_data),
    .we      (we)
  );

  function automatic logic [N-1:0] romWord(input logic [LOGN-1:0] a);
    return N'(1000 + 7 * int'(a));
  endfunction

  // Additive stand-in for the PE pair so every write value is predictable.
  assign pe_p0 = pe_a + pe_b;
  assign pe_p1 = pe_b - pe_a;

  // Cycle counter: cycle k is the interval after the k-th rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  // RAM and ROM models, both with one cycle of read latency.
  always @(posedge clk) begin
    if (preloadReq) begin
      for (int k = 0; k < NW; k++) mem[k] <= N'(100 + k);
    end else if (we) begin
      mem[wa_addr] <= wa_data;
      mem[wb_addr] <= wb_data;
    end
    if (re) begin
      ra_data <= mem[ra_addr];
      rb_data <= mem[rb_addr];
    end
    tf_data <= romWord(tf_addr);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  // Monitor: compares each issue and write against the scoreboard queues
  // and collects the timing of busy, done and the first write.
  always @(negedge clk) begin
    if (rst_n && monitorOn) begin
      if (busy) begin
        if (busyFirst < 0) busyFirst = cyc;
        busyLast = cyc;
        busyCount++;
        checkOutput("pe_inv", 32'(pe_inv), 32'(runInv));
      end
      if (done) begin
        doneCount++;
        if (doneCycle < 0) doneCycle = cyc;
      end
      if (re) begin
        if (issueQ.size() == 0) begin
          checkOutput("unexpected re", 32'(1), 32'(0));
        end else begin
          monIssue = issueQ.pop_front();
          checkOutput("ra_addr", 32'(ra_addr), 32'(monIssue.lo));
          checkOutput("rb_addr", 32'(rb_addr), 32'(monIssue.hi));
          checkOutput("tf_addr", 32'(tf_addr), 32'(monIssue.tf));
        end
      end
      if (we) begin
        if (firstWriteCycle < 0) begin
          firstWriteCycle = cyc;
          firstWa = wa_addr;
          firstWb = wb_addr;
          firstWaData = wa_data;
          firstWbData = wb_data;
        end
        if (writeQ.size() == 0) begin
          checkOutput("unexpected we", 32'(1), 32'(0));
        end else begin
          monWrite = writeQ.pop_front();
          checkOutput("wa_addr", 32'(wa_addr), 32'(monWrite.lo));
          checkOutput("wb_addr", 32'(wb_addr), 32'(monWrite.hi));
          checkOutput("wa_data", 32'(wa_data), 32'(monWrite.d0));
          checkOutput("wb_data", 32'(wb_data), 32'(monWrite.d1));
          checkOutput("pe_tf", 32'(pe_tf), 32'(monWrite.ptf));
        end
      end
    end
  end

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " busy"}, 32'(busy), 32'(0));
    checkOutput({tag, " done"}, 32'(done), 32'(0));
    checkOutput({tag, " re"}, 32'(re), 32'(0));
    checkOutput({tag, " we"}, 32'(we), 32'(0));
    checkOutput({tag, " ra_addr"}, 32'(ra_addr), 32'(0));
    checkOutput({tag, " rb_addr"}, 32'(rb_addr), 32'(0));
    checkOutput({tag, " tf_addr"}, 32'(tf_addr), 32'(0));
    checkOutput({tag, " wa_addr"}, 32'(wa_addr), 32'(0));
    checkOutput({tag, " wb_addr"}, 32'(wb_addr), 32'(0));
    checkOutput({tag, " wa_data"}, 32'(wa_data), 32'(0));
    checkOutput({tag, " wb_data"}, 32'(wb_data), 32'(0));
    checkOutput({tag, " pe_a"}, 32'(pe_a), 32'(0));
    checkOutput({tag, " pe_b"}, 32'(pe_b), 32'(0));
    checkOutput({tag, " pe_tf"}, 32'(pe_tf), 32'(0));
    checkOutput({tag, " pe_inv"}, 32'(pe_inv), 32'(0));
  endtask

  task automatic preloadRam();
    preloadReq = 1'b1;
    @(posedge clk); #1;
    preloadReq = 1'b0;
  endtask

  // Golden transform over a snapshot of the RAM model. Butterflies are
  // enumerated arithmetically: group = i / h, offset j = i % h, and the
  // twiddle index is j * (H / h) with inv selecting the upper ROM half.
  task automatic buildExpectations(input logic invIn);
    issue_t is;
    write_t ws;
    int h, grp, j, lo, hi, tw;
    logic [N-1:0] a, b;
    for (int k = 0; k < NW; k++) golden[k] = mem[k];
    for (int s = 0; s < LOGN; s++) begin
      h = 1 << s;
      for (int i = 0; i < H; i++) begin
        grp = i / h;
        j   = i % h;
        lo  = grp * 2 * h + j;
        hi  = lo + h;
        tw  = j * (H / h) + (invIn ? H : 0);
        a   = golden[lo];
        b   = golden[hi];
        is.lo = LOGN'(lo);
        is.hi = LOGN'(hi);
        is.tf = LOGN'(tw);
        ws.lo = LOGN'(lo);
        ws.hi = LOGN'(hi);
        ws.d0 = a + b;
        ws.d1 = b - a;
        ws.ptf = romWord(LOGN'(tw));
        issueQ.push_back(is);
        writeQ.push_back(ws);
        golden[lo] = ws.d0;
        golden[hi] = ws.d1;
      end
    end
  endtask

  // Starts a transform in cycle startAt (or the next cycle if already
  // past), optionally pulses a stray start at runStart+ignoredAt, and
  // optionally aborts with reset at runStart+abortAt. Without an abort it
  // waits (bounded) for done and checks timing and the final RAM contents.
  task automatic applyStimulus(input logic invIn, input int startAt,
                               input int ignoredAt, input int abortAt);
    buildExpectations(invIn);
    runInv = invIn;
    doneCycle = -1;
    doneCount = 0;
    busyFirst = -1;
    busyLast = -1;
    busyCount = 0;
    firstWriteCycle = -1;
    if (startAt <= cyc) startAt = cyc + 1;
    while (cyc < startAt) begin
      @(posedge clk); #1;
    end
    start = 1'b1;
    inv = invIn;
    runStart = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    inv = ~invIn;
    for (int k = 0; k < RUN_CYCLES + 6; k++) begin
      start = (ignoredAt > 0) && (cyc == runStart + ignoredAt);
      if (abortAt > 0 && cyc == runStart + abortAt) begin
        checkOutput("we before abort", 32'(we), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        checkAllZero("abort");
        issueQ.delete();
        writeQ.delete();
        start = 1'b0;
        return;
      end
      if (doneCycle >= 0) break;
      @(posedge clk); #1;
    end
    start = 1'b0;
    @(posedge clk); #1;
    if (doneCycle < 0) begin
      checkOutput("done timeout", 32'(0), 32'(1));
    end else begin
      checkOutput("done cycle", 32'(doneCycle), 32'(runStart + 1 + RUN_CYCLES));
    end
    checkOutput("done pulses", 32'(doneCount), 32'(1));
    checkOutput("busy first", 32'(busyFirst), 32'(runStart + 1));
    checkOutput("busy last", 32'(busyLast), 32'(runStart + RUN_CYCLES));
    checkOutput("busy cycles", 32'(busyCount), 32'(RUN_CYCLES));
    checkOutput("first write cycle", 32'(firstWriteCycle), 32'(runStart + 3));
    checkOutput("issues left", 32'(issueQ.size()), 32'(0));
    checkOutput("writes left", 32'(writeQ.size()), 32'(0));
    for (int k = 0; k < NW; k++) begin
      checkOutput($sformatf("ram[%0d]", k), 32'(mem[k]), 32'(golden[k]));
    end
  endtask

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    inv = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    rst_n = 1'b1;
    monitorOn = 1'b1;

    $display("[TB] NTT run, start at cycle 10");
    preloadRam();
    applyStimulus(1'b0, 10, 0, 0);
    checkOutput("first wa_addr", 32'(firstWa), 32'(0));
    checkOutput("first wa_data", 32'(firstWaData), 32'(201));
    checkOutput("first wb_addr", 32'(firstWb), 32'(1));
    checkOutput("first wb_data", 32'(firstWbData), 32'(1));

    $display("[TB] INTT run with a stray start at T+5");
    preloadRam();
    applyStimulus(1'b1, 0, 5, 0);

    $display("[TB] INTT run aborted by reset in stage 1");
    preloadRam();
    applyStimulus(1'b1, 0, 0, 9);
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("held reset");
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      checkOutput("post-reset busy", 32'(busy), 32'(0));
      checkOutput("post-reset re", 32'(re), 32'(0));
      checkOutput("post-reset we", 32'(we), 32'(0));
    end

    $display("[TB] NTT run after abort");
    preloadRam();
    applyStimulus(1'b0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
